// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the Harvard memory model.
// Used by the region decoder and the memory top.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        MEM_CLEAR,
        MEM_LOAD,
        MEM_RUN
    } mem_state_t;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_ROM,
        REG_RAM
    } region_t;

    localparam logic [31:0] ROM_BASE_DEF = 32'hBFC00000;
    localparam logic [31:0] RAM_BASE_DEF = 32'h00000000;

endpackage

// File: rtl/mem_region_decode.sv
// Maps a byte address onto the ROM or RAM region and a word index.
// ROM is checked first; bases are assumed word aligned.
module mem_region_decode
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] ROM_BASE  = ROM_BASE_DEF,
    parameter int          ROM_WORDS = 256,
    parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF,
    parameter int          RAM_WORDS = 1024,
    parameter int          IW        = 10
) (
    input  logic [31:0]   addr,
    output region_t       region,
    output logic [IW-1:0] idx,
    output logic          misaligned
);

    logic [31:0] rom_w;
    logic [31:0] ram_w;

    // Word offsets into each region; a hit is an offset below the depth.
    always_comb begin
        rom_w  = (addr - ROM_BASE) >> 2;
        ram_w  = (addr - RAM_BASE) >> 2;
        region = REG_NONE;
        idx    = '0;
        if (rom_w < 32'(ROM_WORDS)) begin
            region = REG_ROM;
            idx    = rom_w[IW-1:0];
        end else if (ram_w < 32'(RAM_WORDS)) begin
            region = REG_RAM;
            idx    = ram_w[IW-1:0];
        end
    end

    assign misaligned = (addr[1:0] != 2'b00);

endmodule

// File: rtl/mips_harvard_mem.sv
// Harvard memory responder: boot ROM plus data RAM for the CPU.
// Clears RAM after reset, accepts a loader image, then serves the CPU.
module mips_harvard_mem
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] ROM_BASE  = ROM_BASE_DEF,
    parameter int          ROM_WORDS = 256,
    parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF,
    parameter int          RAM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_write,
    input  logic        data_read,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        mem_ready,
    output logic        err_flag,
    output logic [15:0] err_count
);

    localparam int ROM_AW = $clog2(ROM_WORDS);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int IW     = (ROM_AW > RAM_AW) ? ROM_AW : RAM_AW;

    mem_state_t        state;
    mem_state_t        state_nx;
    logic [RAM_AW-1:0] clear_idx;

    logic [31:0] rom [ROM_WORDS];
    logic [31:0] ram [RAM_WORDS];

    region_t       i_reg, d_reg, l_reg;
    logic [IW-1:0] i_idx, d_idx, l_idx;
    logic          i_mis_unused, d_mis, l_mis;

    logic load_fire, load_ok, load_err;
    logic run_en, strobe, cpu_err, cpu_commit;

    mem_region_decode #(
        .ROM_BASE(ROM_BASE), .ROM_WORDS(ROM_WORDS),
        .RAM_BASE(RAM_BASE), .RAM_WORDS(RAM_WORDS), .IW(IW)
    ) u_dec_instr (
        .addr(instr_address), .region(i_reg),
        .idx(i_idx), .misaligned(i_mis_unused)
    );

    mem_region_decode #(
        .ROM_BASE(ROM_BASE), .ROM_WORDS(ROM_WORDS),
        .RAM_BASE(RAM_BASE), .RAM_WORDS(RAM_WORDS), .IW(IW)
    ) u_dec_data (
        .addr(data_address), .region(d_reg),
        .idx(d_idx), .misaligned(d_mis)
    );

    mem_region_decode #(
        .ROM_BASE(ROM_BASE), .ROM_WORDS(ROM_WORDS),
        .RAM_BASE(RAM_BASE), .RAM_WORDS(RAM_WORDS), .IW(IW)
    ) u_dec_load (
        .addr(load_addr), .region(l_reg),
        .idx(l_idx), .misaligned(l_mis)
    );

    // State register; reset always returns to the RAM clear pass.
    always_ff @(posedge clk) begin
        if (reset) state <= MEM_CLEAR;
        else       state <= state_nx;
    end

    // Next state: clear sweep, then loader until the last beat, then run.
    always_comb begin
        state_nx = state;
        unique case (state)
            MEM_CLEAR: if (clear_idx == RAM_AW'(RAM_WORDS - 1)) state_nx = MEM_LOAD;
            MEM_LOAD:  if (load_fire && load_last) state_nx = MEM_RUN;
            MEM_RUN:   state_nx = MEM_RUN;
            default:   state_nx = MEM_CLEAR;
        endcase
    end

    // Handshake outputs follow the state directly.
    always_comb begin
        load_ready = 1'b0;
        mem_ready  = 1'b0;
        unique case (state)
            MEM_LOAD: load_ready = 1'b1;
            MEM_RUN:  mem_ready  = 1'b1;
            default:  ;
        endcase
    end

    // Loader and CPU access qualification.
    always_comb begin
        load_fire  = load_valid && load_ready;
        load_ok    = (l_reg != REG_NONE) && !l_mis;
        load_err   = load_fire && !load_ok;
        run_en     = (state == MEM_RUN) && clk_enable;
        strobe     = data_read || data_write;
        cpu_err    = run_en && ((strobe && d_reg == REG_NONE)
                             || (data_write && d_reg == REG_ROM)
                             || (data_write && data_read)
                             || (strobe && d_mis));
        cpu_commit = run_en && data_write && d_reg == REG_RAM && !d_mis;
    end

    // Clear index walks the RAM once per clear pass.
    always_ff @(posedge clk) begin
        if (reset)                   clear_idx <= '0;
        else if (state == MEM_CLEAR) clear_idx <= clear_idx + 1'b1;
    end

    // RAM writes: clear sweep, loader beats, then CPU stores.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == MEM_CLEAR)
                ram[clear_idx] <= '0;
            else if (load_fire && load_ok && l_reg == REG_RAM)
                ram[l_idx[RAM_AW-1:0]] <= load_data;
            else if (cpu_commit)
                ram[d_idx[RAM_AW-1:0]] <= data_writedata;
        end
    end

    // ROM is only written by the loader.
    always_ff @(posedge clk) begin
        if (!reset && load_fire && load_ok && l_reg == REG_ROM)
            rom[l_idx[ROM_AW-1:0]] <= load_data;
    end

    // Sticky error flag and saturating CPU error counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_flag  <= 1'b0;
            err_count <= '0;
        end else begin
            if (load_err || cpu_err) err_flag <= 1'b1;
            if (cpu_err && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end

    // Zero-latency read ports; misses return zero.
    always_comb begin
        instr_readdata = '0;
        data_readdata  = '0;
        case (i_reg)
            REG_ROM: instr_readdata = rom[i_idx[ROM_AW-1:0]];
            REG_RAM: instr_readdata = ram[i_idx[RAM_AW-1:0]];
            default: instr_readdata = '0;
        endcase
        case (d_reg)
            REG_ROM: data_readdata = rom[d_idx[ROM_AW-1:0]];
            REG_RAM: data_readdata = ram[d_idx[RAM_AW-1:0]];
            default: data_readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_mips_harvard_mem.sv
// Bench for mips_harvard_mem: directed table, randomized run phase
// against an address-range memory model, and a mid-load reset.
module tb_mips_harvard_mem;

    localparam logic [31:0] ROMB = 32'hBFC00000;
    localparam int          ROMW = 256;
    localparam int          RAMW = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_last;
    logic        mem_ready;
    logic        err_flag;
    logic [15:0] err_count;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rom_m [ROMW];
    logic [31:0] ram_m [RAMW];
    int          m_cnt;
    logic        m_flag;

    mips_harvard_mem dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .instr_address(instr_address), .instr_readdata(instr_readdata),
        .data_address(data_address), .data_write(data_write),
        .data_read(data_read), .data_writedata(data_writedata),
        .data_readdata(data_readdata),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_data(load_data),
        .load_last(load_last), .mem_ready(mem_ready),
        .err_flag(err_flag), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // 0 = miss, 1 = ROM, 2 = RAM, from plain address ranges.
    function automatic int m_region(input logic [31:0] a);
        if (a >= ROMB && (a - ROMB) < 32'(ROMW * 4)) return 1;
        if (a < 32'(RAMW * 4)) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int r = m_region(a);
        if (r == 1) return rom_m[int'((a - ROMB) / 4)];
        if (r == 2) return ram_m[int'(a / 4)];
        return 32'h0;
    endfunction

    task automatic m_step(input logic ce, input logic we, input logic re,
                          input logic [31:0] a, input logic [31:0] wd);
        int  r;
        bit  err;
        r = m_region(a);
        if (!ce) return;
        err = ((we || re) && r == 0) || (we && r == 1) || (we && re)
              || ((we || re) && a[1:0] != 2'b00);
        if (err) begin
            m_flag = 1'b1;
            if (m_cnt < 65535) m_cnt++;
        end
        if (we && r == 2 && a[1:0] == 2'b00) ram_m[int'(a / 4)] = wd;
    endtask

    // One CPU cycle: starts and ends on a negedge, strobes dropped after.
    task automatic cpu_cycle(input logic ce, input logic we, input logic re,
                             input logic [31:0] a, input logic [31:0] wd);
        clk_enable     = ce;
        data_write     = we;
        data_read      = re;
        data_address   = a;
        data_writedata = wd;
        @(posedge clk);
        m_step(ce, we, re, a, wd);
        @(negedge clk);
        clk_enable = 1'b0;
        data_write = 1'b0;
        data_read  = 1'b0;
    endtask

    task automatic load_beat(input logic [31:0] a, input logic [31:0] d,
                             input logic last);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        load_last  = last;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_load(input string name);
        int n = 0;
        while (load_ready !== 1'b1 && n < 2000) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check32(name, n, 1024);
    endtask

    task automatic rd_check(input string name, input logic [31:0] a,
                            input logic [31:0] exp);
        data_address = a;
        #1;
        check32(name, data_readdata, exp);
    endtask

    typedef struct {
        string       name;
        logic        ce;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] chk_addr;
        logic [31:0] exp_rd;
        logic [15:0] exp_cnt;
        logic        exp_flag;
    } vec_t;

    vec_t tbl [$];

    initial begin
        reset = 1'b1; clk_enable = 1'b0;
        instr_address = 32'h0; data_address = 32'h0;
        data_write = 1'b0; data_read = 1'b0; data_writedata = 32'h0;
        load_valid = 1'b0; load_addr = 32'h0; load_data = 32'h0;
        load_last = 1'b0;

        tbl.push_back('{"wr_ce1", 1,1,0, 32'h20, 32'h12345678, 32'h20, 32'h12345678, 16'd0, 0});
        tbl.push_back('{"wr_ce0", 0,1,0, 32'h20, 32'hCAFEF00D, 32'h20, 32'h12345678, 16'd0, 0});
        tbl.push_back('{"wr_rom", 1,1,0, ROMB, 32'h11111111, ROMB, 32'h24020005, 16'd1, 1});
        tbl.push_back('{"rd_miss", 1,0,1, 32'h80000000, 32'h0, 32'h80000000, 32'h0, 16'd2, 1});
        tbl.push_back('{"rd_misal", 1,0,1, 32'h22, 32'h0, 32'h20, 32'h12345678, 16'd3, 1});
        tbl.push_back('{"rw_both", 1,1,1, 32'h24, 32'h55AA55AA, 32'h24, 32'h55AA55AA, 16'd4, 1});
        tbl.push_back('{"rd_ram", 1,0,1, 32'h10, 32'h0, 32'h10, 32'hDEADBEEF, 16'd4, 1});
        tbl.push_back('{"wr_ram_top", 1,1,0, 32'hFFC, 32'hA5A5A5A5, 32'hFFC, 32'hA5A5A5A5, 16'd4, 1});
        tbl.push_back('{"wr_ram_over", 1,1,0, 32'h1000, 32'h77777777, 32'h1000, 32'h0, 16'd5, 1});
        tbl.push_back('{"rd_rom_top", 1,0,1, ROMB + 32'h3FC, 32'h0, ROMB + 32'h3FC, 32'h0BADF00D, 16'd5, 1});
        tbl.push_back('{"rd_rom_over", 1,0,1, ROMB + 32'h400, 32'h0, ROMB + 32'h400, 32'h0, 16'd6, 1});
        tbl.push_back('{"ce0_miss", 0,0,1, 32'h80000000, 32'h0, 32'h24, 32'h55AA55AA, 16'd6, 1});
        tbl.push_back('{"wr_misal", 1,1,0, 32'h26, 32'h99999999, 32'h24, 32'h55AA55AA, 16'd7, 1});
        tbl.push_back('{"idle_miss", 1,0,0, 32'h80000000, 32'h0, 32'h0, 32'h0, 16'd7, 1});

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("rst_load_ready", load_ready, 0);
        check32("rst_mem_ready", mem_ready, 0);
        check32("rst_err_flag", err_flag, 0);
        check32("rst_err_count", err_count, 0);
        reset = 1'b0;

        // Clear window: exactly RAMW cycles with both handshakes low.
        begin
            int bad = 0;
            for (int i = 0; i < RAMW; i++) begin
                if (load_ready !== 1'b0 || mem_ready !== 1'b0) bad++;
                @(posedge clk);
                @(negedge clk);
            end
            check32("clear_window", bad, 0);
        end
        check32("load_ready_rise", load_ready, 1);
        check32("load_mem_ready", mem_ready, 0);
        rd_check("clear_zero_lo", 32'h10, 32'h0);
        rd_check("clear_zero_hi", 32'hFFC, 32'h0);

        // Image load.
        load_beat(ROMB, 32'h24020005, 1'b0);
        load_beat(ROMB + 32'h3FC, 32'h0BADF00D, 1'b0);
        load_beat(32'h10, 32'hDEADBEEF, 1'b1);
        check32("run_mem_ready", mem_ready, 1);
        check32("run_load_ready", load_ready, 0);
        check32("run_err_flag", err_flag, 0);
        for (int i = 0; i < RAMW; i++) ram_m[i] = 32'h0;
        ram_m[4] = 32'hDEADBEEF;
        rom_m[0] = 32'h24020005;
        rom_m[255] = 32'h0BADF00D;
        m_cnt = 0;
        m_flag = 1'b0;

        instr_address = ROMB;
        #1 check32("instr_rom", instr_readdata, 32'h24020005);
        instr_address = 32'h10;
        #1 check32("instr_ram", instr_readdata, 32'hDEADBEEF);
        instr_address = 32'h80000000;
        #1 check32("instr_miss", instr_readdata, 32'h0);
        rd_check("data_loaded", 32'h10, 32'hDEADBEEF);

        // Loader is ignored once running.
        load_beat(32'h10, 32'h0, 1'b1);
        rd_check("run_load_ignored", 32'h10, 32'hDEADBEEF);

        // Directed table.
        foreach (tbl[k]) begin
            cpu_cycle(tbl[k].ce, tbl[k].we, tbl[k].re, tbl[k].addr, tbl[k].wdata);
            rd_check({tbl[k].name, "_rd"}, tbl[k].chk_addr, tbl[k].exp_rd);
            check32({tbl[k].name, "_cnt"}, err_count, tbl[k].exp_cnt);
            check32({tbl[k].name, "_flag"}, err_flag, tbl[k].exp_flag);
        end

        // Randomized run phase against the model.
        for (int it = 0; it < 400; it++) begin
            logic [31:0] a;
            logic [31:0] ia;
            int          kind;
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1: a = 32'($urandom_range(0, 31)) * 4;
                2:    a = 32'hF80 + 32'($urandom_range(0, 31)) * 4;
                3:    a = ($urandom_range(0, 1) == 0) ? ROMB : ROMB + 32'h3FC;
                4:    a = 32'h80000000 | ($urandom & 32'h0FFFFFFC);
                default: a = 32'($urandom_range(0, 31)) * 4
                             + 32'($urandom_range(1, 3));
            endcase
            cpu_cycle($urandom_range(0, 3) != 0, 1'($urandom),
                      1'($urandom), a, $urandom);
            rd_check("rand_rd", a, m_read(a));
            ia = 32'($urandom_range(0, 31)) * 4;
            instr_address = ia;
            #1 check32("rand_instr", instr_readdata, m_read(ia));
            check32("rand_cnt", err_count, 32'(m_cnt));
            check32("rand_flag", err_flag, m_flag);
        end

        // Reset mid-load: RAM re-cleared and error flag dropped.
        do_reset();
        wait_load("reclear_len");
        load_beat(32'h40, 32'h11111111, 1'b0);
        load_beat(32'h42, 32'h22222222, 1'b0);
        load_beat(32'h44, 32'h33333333, 1'b0);
        check32("load_err_flag", err_flag, 1);
        check32("load_err_count", err_count, 0);
        check32("load_mem_ready_lo", mem_ready, 0);
        rd_check("load_wr_40", 32'h40, 32'h11111111);
        rd_check("load_wr_44", 32'h44, 32'h33333333);
        do_reset();
        check32("midrst_err_flag", err_flag, 0);
        check32("midrst_load_ready", load_ready, 0);
        wait_load("midrst_clear_len");
        rd_check("midrst_zero_40", 32'h40, 32'h0);
        rd_check("midrst_zero_44", 32'h44, 32'h0);
        rd_check("midrst_zero_24", 32'h24, 32'h0);
        rd_check("midrst_zero_10", 32'h10, 32'h0);
        rd_check("midrst_zero_ffc", 32'hFFC, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
